// File: rtl/sprite_draw_controller.sv
// Sprite / background draw sequencer.
//
// Presents a linear address stream to either the sprite ROM (40x40) or the
// screen ROM (160x120). Each ROM returns its colour one cycle after the
// address. That colour becomes a pixel write for the 160x120 VGA adapter.
//   mode 0 : sprite blit at (originX, originY). Pixels that fall off-screen
//            and pixels of colour TRANSPARENT are not plotted.
//   mode 1 : full-screen background copy.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   start, mode          draw request and mode; mode is latched with start
//   originX, originY     sprite origin; latched with start
//   romColour            ROM data for the address of the previous cycle
//   spriteAddr           sprite ROM address (0 in mode 1)
//   screenAddr           screen ROM address (0 in mode 0)
//   vgaX, vgaY           pixel coordinates
//   vgaColour            pixel colour
//   plot                 VGA write strobe
//   busy                 high while a draw is in progress
//   done                 one-cycle completion pulse
module sprite_draw_controller #(
   parameter int unsigned SPRITE_W    = 40,
   parameter int unsigned SPRITE_H    = 40,
   parameter int unsigned SCREEN_W    = 160,
   parameter int unsigned SCREEN_H    = 120,
   parameter logic [2:0]  TRANSPARENT = 3'b101
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        mode,
   input  logic [7:0]  originX,
   input  logic [6:0]  originY,
   input  logic [2:0]  romColour,
   output logic [10:0] spriteAddr,
   output logic [14:0] screenAddr,
   output logic [7:0]  vgaX,
   output logic [6:0]  vgaY,
   output logic [2:0]  vgaColour,
   output logic        plot,
   output logic        busy,
   output logic        done
);

   localparam int unsigned SPRITE_N = SPRITE_W * SPRITE_H;
   localparam int unsigned SCREEN_N = SCREEN_W * SCREEN_H;

   typedef enum logic [1:0] {StIdle, StDraw, StFlush, StDone} state_e;

   state_e      state_q;
   logic        mode_q;
   logic [7:0]  ox_q;
   logic [6:0]  oy_q;
   logic [7:0]  col_q;
   logic [6:0]  row_q;
   logic [14:0] addr_q;
   logic        busy_q;
   logic        done_q;

   // Pipeline stage aligned with romColour.
   logic        p_valid_q;
   logic [7:0]  p_col_q;
   logic [6:0]  p_row_q;

   // Last pixel driven, held while no stage data is valid.
   logic [7:0]  x_hold_q;
   logic [6:0]  y_hold_q;
   logic [2:0]  c_hold_q;

   logic [14:0] last_addr;
   logic [7:0]  col_last;
   logic [8:0]  sx;
   logic [8:0]  sy;
   logic [7:0]  x_live;
   logic [6:0]  y_live;
   logic        plot_live;

   always_comb begin
      last_addr = mode_q ? 15'(SCREEN_N - 1) : 15'(SPRITE_N - 1);
      col_last  = mode_q ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StIdle;
         mode_q    <= 1'b0;
         ox_q      <= '0;
         oy_q      <= '0;
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         p_valid_q <= 1'b0;
         p_col_q   <= '0;
         p_row_q   <= '0;
         x_hold_q  <= '0;
         y_hold_q  <= '0;
         c_hold_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mode_q  <= mode;
                  ox_q    <= originX;
                  oy_q    <= originY;
                  col_q   <= '0;
                  row_q   <= '0;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StDraw;
               end
            end
            StDraw: begin
               // The final address stays on the bus after the draw ends.
               if (addr_q == last_addr) begin
                  state_q <= StFlush;
               end else begin
                  addr_q <= addr_q + 15'd1;
                  if (col_q == col_last) begin
                     col_q <= '0;
                     row_q <= row_q + 7'd1;
                  end else begin
                     col_q <= col_q + 8'd1;
                  end
               end
            end
            StFlush: begin
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         p_valid_q <= (state_q == StDraw);
         p_col_q   <= col_q;
         p_row_q   <= row_q;

         if (p_valid_q) begin
            x_hold_q <= x_live;
            y_hold_q <= y_live;
            c_hold_q <= romColour;
         end
      end
   end

   // Screen coordinates are 9 bits wide so an origin near the edge cannot
   // wrap back onto the visible area.
   always_comb begin
      sx = {1'b0, ox_q} + {1'b0, p_col_q};
      sy = {2'b00, oy_q} + {2'b00, p_row_q};
      if (mode_q) begin
         x_live    = p_col_q;
         y_live    = p_row_q;
         plot_live = p_valid_q;
      end else begin
         x_live    = sx[7:0];
         y_live    = sy[6:0];
         plot_live = p_valid_q && (sx < 9'(SCREEN_W)) && (sy < 9'(SCREEN_H)) &&
                     (romColour != TRANSPARENT);
      end
   end

   always_comb begin
      spriteAddr = mode_q ? 11'd0 : addr_q[10:0];
      screenAddr = mode_q ? addr_q : 15'd0;
      vgaX       = p_valid_q ? x_live : x_hold_q;
      vgaY       = p_valid_q ? y_live : y_hold_q;
      vgaColour  = p_valid_q ? romColour : c_hold_q;
      plot       = plot_live;
      busy       = busy_q;
      done       = done_q;
   end

endmodule
